// File: rtl/ux607_pwm_gen2_core.sv
// Parametrised PWM core: NCH compare channels with shadowed compare registers,
// output polarity inversion and a sticky period-wrap flag behind a valid/bits/read register bus.
module ux607_pwm_gen2_core #(
  parameter int NCH   = 4,
  parameter int CMP_W = 16,
  parameter int CNT_W = 31
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_regs_cfg_write_valid,
  input  logic [31:0]            io_regs_cfg_write_bits,
  output logic [31:0]            io_regs_cfg_read,
  input  logic                   io_regs_count_write_valid,
  input  logic [31:0]            io_regs_count_write_bits,
  output logic [31:0]            io_regs_count_read,
  output logic [CMP_W-1:0]       io_regs_s_read,
  input  logic [NCH-1:0]         io_regs_cmp_write_valid,
  input  logic [NCH*CMP_W-1:0]   io_regs_cmp_write_bits,
  output logic [NCH*CMP_W-1:0]   io_regs_cmp_read,
  input  logic                   io_regs_center_write_valid,
  input  logic [NCH-1:0]         io_regs_center_write_bits,
  output logic [NCH-1:0]         io_regs_center_read,
  input  logic                   io_regs_gang_write_valid,
  input  logic [NCH-1:0]         io_regs_gang_write_bits,
  output logic [NCH-1:0]         io_regs_gang_read,
  input  logic                   io_regs_invert_write_valid,
  input  logic [NCH-1:0]         io_regs_invert_write_bits,
  output logic [NCH-1:0]         io_regs_invert_read,
  input  logic                   io_regs_ip_write_valid,
  input  logic [NCH-1:0]         io_regs_ip_write_bits,
  output logic [NCH-1:0]         io_regs_ip_read,
  output logic [NCH-1:0]         io_ip,
  output logic [NCH-1:0]         io_gpio,
  output logic                   io_wrap
);

  logic [3:0]       scale_r;
  logic             sticky_r, zerocmp_r, deglitch_r, cmpsync_r, enalways_r, oneshot_r, wrap_r, dg_r;
  logic [CNT_W-1:0] count_r;
  logic [CMP_W-1:0] shadow_r [NCH];
  logic [CMP_W-1:0] act_r [NCH];
  logic [NCH-1:0]   center_r, gang_r, invert_r, ip_r;

  logic             count_en_s, feed_s, count_reset_s;
  logic [CNT_W-1:0] shifted_s, low_mask_s;
  logic [31:0]      mask_shift_s;
  logic [CMP_W-1:0] s_s;
  logic [CMP_W-1:0] sel_s [NCH];
  logic [NCH-1:0]   elapsed_s, ip_hw_s;
  logic             unused_s;

  assign unused_s = ^{io_regs_cfg_write_bits[30:14], io_regs_cfg_write_bits[7:4],
                      (io_regs_count_write_bits >> CNT_W), (shifted_s >> CMP_W)};

  // Scaled count and carry-out of the scaled window (period end)
  always_comb begin
    count_en_s    = enalways_r | oneshot_r;
    shifted_s     = count_r >> scale_r;
    s_s           = shifted_s[CMP_W-1:0];
    mask_shift_s  = 32'(CNT_W - CMP_W) - {28'd0, scale_r};
    low_mask_s    = {CNT_W{1'b1}} >> mask_shift_s;
    feed_s        = count_en_s & ((count_r & low_mask_s) == low_mask_s);
    count_reset_s = feed_s | (zerocmp_r & elapsed_s[0]);
  end

  // Per-channel compare, with center-aligned channels folding s about mid-range
  always_comb begin
    elapsed_s = '0;
    ip_hw_s   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (center_r[i] & s_s[CMP_W-1]) begin
        sel_s[i] = ~s_s;
      end else begin
        sel_s[i] = s_s;
      end
      elapsed_s[i] = (sel_s[i] >= act_r[i]);
      if (center_r[i]) begin
        ip_hw_s[i] = elapsed_s[i];
      end else begin
        ip_hw_s[i] = elapsed_s[i] | (dg_r & ip_r[i]);
      end
    end
  end

  // Outputs and register read-back
  always_comb begin
    io_gpio          = '0;
    io_regs_cmp_read = '0;
    for (int i = 0; i < NCH; i++) begin
      io_gpio[i] = (ip_r[i] & ~(gang_r[i] & ip_r[(i + 1) % NCH])) ^ invert_r[i];
      io_regs_cmp_read[i*CMP_W +: CMP_W] = shadow_r[i];
    end
  end

  assign io_regs_cfg_read    = {wrap_r, 17'd0, oneshot_r, enalways_r, cmpsync_r, deglitch_r,
                                zerocmp_r, sticky_r, 4'd0, scale_r};
  assign io_regs_count_read  = 32'(count_r);
  assign io_regs_s_read      = s_s;
  assign io_regs_center_read = center_r;
  assign io_regs_gang_read   = gang_r;
  assign io_regs_invert_read = invert_r;
  assign io_regs_ip_read     = ip_r;
  assign io_ip               = ip_r;
  assign io_wrap             = wrap_r;

  // Configuration, one-shot, wrap flag and deglitch state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scale_r    <= 4'd0;
      sticky_r   <= 1'b0;
      zerocmp_r  <= 1'b0;
      deglitch_r <= 1'b0;
      cmpsync_r  <= 1'b0;
      enalways_r <= 1'b0;
      oneshot_r  <= 1'b0;
      wrap_r     <= 1'b0;
      dg_r       <= 1'b0;
    end else begin
      if (io_regs_cfg_write_valid) begin
        scale_r    <= io_regs_cfg_write_bits[3:0];
        sticky_r   <= io_regs_cfg_write_bits[8];
        zerocmp_r  <= io_regs_cfg_write_bits[9];
        deglitch_r <= io_regs_cfg_write_bits[10];
        cmpsync_r  <= io_regs_cfg_write_bits[11];
        enalways_r <= io_regs_cfg_write_bits[12];
      end
      // A period end always disarms the one-shot, even against a concurrent cfg write
      if (io_regs_cfg_write_valid | count_reset_s) begin
        oneshot_r <= io_regs_cfg_write_bits[13] & ~count_reset_s;
      end
      if (count_reset_s) begin
        wrap_r <= 1'b1;
      end else if (io_regs_cfg_write_valid & io_regs_cfg_write_bits[31]) begin
        wrap_r <= 1'b0;
      end
      dg_r <= (deglitch_r & ~count_reset_s) | sticky_r;
    end
  end

  // Raw counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (count_reset_s) begin
      count_r <= '0;
    end else if (io_regs_count_write_valid) begin
      count_r <= io_regs_count_write_bits[CNT_W-1:0];
    end else begin
      count_r <= count_r + CNT_W'(count_en_s);
    end
  end

  // Shadow and active compare registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_r[i] <= '0;
        act_r[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (io_regs_cmp_write_valid[i]) begin
          shadow_r[i] <= io_regs_cmp_write_bits[i*CMP_W +: CMP_W];
        end
        if (cmpsync_r & count_reset_s) begin
          act_r[i] <= io_regs_cmp_write_valid[i] ? io_regs_cmp_write_bits[i*CMP_W +: CMP_W]
                                                 : shadow_r[i];
        end else if (~cmpsync_r & io_regs_cmp_write_valid[i]) begin
          act_r[i] <= io_regs_cmp_write_bits[i*CMP_W +: CMP_W];
        end
      end
    end
  end

  // Channel control registers and pending bits; software writes beat hardware updates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      center_r <= '0;
      gang_r   <= '0;
      invert_r <= '0;
      ip_r     <= '0;
    end else begin
      if (io_regs_center_write_valid) center_r <= io_regs_center_write_bits;
      if (io_regs_gang_write_valid)   gang_r   <= io_regs_gang_write_bits;
      if (io_regs_invert_write_valid) invert_r <= io_regs_invert_write_bits;
      ip_r <= io_regs_ip_write_valid ? io_regs_ip_write_bits : ip_hw_s;
    end
  end

endmodule
